line_delay_buffer: RTL
======================

// Module: line_delay_buffer
// PURPOSE
//   Parametrised multi-tap line delay for the Sobel window front end. Replaces the fixed
//   8-bit shift-register FIFO chain with a circular-pointer RAM buffer of NUM_TAPS cascaded
//   line delays, each LINE_LEN samples long. Adds per-tap valid flags, an end-of-line strobe
//   and optional zero masking. Sits between the pixel source and the 3x3 window register.
// PARAMETERS
//   DATA_W    8    sample width in bits
//   LINE_LEN  256  samples per line (delay per tap); legal range >= 2
//   NUM_TAPS  2    cascaded line delays; legal range 1..4
// PORTS
//   CLK      in   1                rising-edge clock
//   RSTn     in   1                synchronous reset, active low
//   Enable   in   1                sample advance; all state holds when 0
//   DataIn   in   DATA_W           incoming sample
//   DataOut  out  NUM_TAPS*DATA_W  tap k at [k*DATA_W +: DATA_W]
//   TapValid out  NUM_TAPS         bit k = DataOut tap k holds real data
//   LineEnd  out  1                one-cycle strobe after the last sample of a line
// BEHAVIOUR
//   One clock (CLK). Reset is synchronous and active-low (RSTn).
//   Reset (RSTn=0 at a rising edge; overrides Enable): ptr=0, fill=0, DataOut=0, TapValid=0,
//     LineEnd=0. RAM contents are not cleared; stale data is masked by TapValid.
//   Storage: NUM_TAPS arrays mem_k[LINE_LEN] of DATA_W bits. ptr counts 0..LINE_LEN-1.
//   Enabled edge (RSTn=1, Enable=1), for every tap k in parallel, read-before-write:
//     DataOut_k <= mem_k[ptr]; mem_k[ptr] <= in_k, where in_0=DataIn, in_k=old mem_{k-1}[ptr].
//     ptr <= (ptr==LINE_LEN-1) ? 0 : ptr+1 (wrap, no gap).
//   Latency: after enabled edge n, tap k = DataIn sampled at enabled edge n-(k+1)*LINE_LEN.
//     Latency is counted in enabled edges only. Cycles with Enable=0 add nothing.
//   Fill counter: increments on each enabled edge and saturates at NUM_TAPS*LINE_LEN+1.
//     TapValid[k] is registered. It is 1 once fill >= (k+1)*LINE_LEN+1, i.e. from the
//     output of enabled edge (k+1)*LINE_LEN+1 onward. It stays 1 until reset.
//   LineEnd <= 1 on an enabled edge where ptr==LINE_LEN-1. Every other edge sets it to 0,
//     including edges with Enable=0. It is never high for two consecutive cycles.
//   Enable=0 (RSTn=1): ptr, fill, RAM, DataOut and TapValid hold. LineEnd clears to 0.
//   Reset mid-operation: all flags drop on that edge. Refill restarts from fill=0, so tap 0
//     is valid again LINE_LEN+1 enabled edges after RSTn returns high.
//   Widths: ptr is $clog2(LINE_LEN) bits. fill is $clog2(NUM_TAPS*LINE_LEN+2) bits.
//     No arithmetic is done on the data path.
//   RAM is inferred as one synchronous read/write port per tap. No combinational path
//     from DataIn to any output.
// CONFIGURATION
//   TAP_ZERO_MASK_EN defined: DataOut tap k is forced to 0 while TapValid[k]=0. The mask
//     applies on the registered output, so the zero tracks TapValid on the same cycle.
//     Intended for Sobel border handling.
//   TAP_ZERO_MASK_EN undefined: DataOut shows raw RAM data at all times, with no mask
//     logic. Before TapValid the value is indeterminate; X is allowed in simulation.
// TESTING  (DATA_W=8, LINE_LEN=256, NUM_TAPS=2 unless noted)
//   1 Reset: RSTn=0 for 3 cycles with Enable=1 and DataIn=8'hAA
//     -> DataOut=0, TapValid=2'b00, LineEnd=0 on every cycle.
//   2 Ramp: Enable=1, DataIn=n[7:0] at enabled edge n=1,2,...
//     -> after edge 257: tap0=8'h01, TapValid=2'b01.
//     -> after edge 513: tap1=8'h01, TapValid=2'b11.
//     -> after edge 600: tap0=8'h58 (344), tap1=8'h58 (88).
//   3 Stall: same ramp with Enable toggled every other cycle -> identical tap sequence
//     indexed by enabled edges; outputs unchanged across Enable=0 cycles.
//   4 Line strobe: continuous Enable -> LineEnd=1 only in the cycles after edges 256, 512
//     and 768. A stall right after edge 256 still gives a 1-cycle pulse.
//   5 Mid-op reset: RSTn=0 for 1 cycle after edge 300, then resume the ramp
//     -> TapValid=2'b00 at once; TapValid[0] rises after the 257th post-reset enabled edge.
//   6 Macro: compile with and without TAP_ZERO_MASK_EN and check edges 1..256.
//     -> with the macro: tap0=0 on every one of those edges.
//     -> without the macro: tap0 follows RAM contents; TapValid timing is identical.

Source files
------------

// File: rtl/line_delay_buffer_if.sv
// Sample stream bundle for line_delay_buffer: advance/data in, tapped lines and flags out.
interface line_delay_buffer_if #(
    parameter int DATA_W   = 8,
    parameter int NUM_TAPS = 2
);
    logic                         Enable;
    logic [DATA_W-1:0]            DataIn;
    logic [NUM_TAPS*DATA_W-1:0]   DataOut;
    logic [NUM_TAPS-1:0]          TapValid;
    logic                         LineEnd;

    modport master (output Enable, DataIn, input DataOut, TapValid, LineEnd);
    modport slave  (input Enable, DataIn, output DataOut, TapValid, LineEnd);
endinterface

// File: rtl/line_delay_buffer.sv
// Multi-tap circular-pointer line delay feeding the Sobel 3x3 window.
// Optional feature: define TAP_ZERO_MASK_EN to zero each tap until its TapValid is set.
module line_delay_buffer #(
    parameter int DATA_W   = 8,
    parameter int LINE_LEN = 256,
    parameter int NUM_TAPS = 2
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    line_delay_buffer_if.slave    bus
);
    localparam int PTR_W  = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam int FILL_W = $clog2(NUM_TAPS*LINE_LEN + 2);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(LINE_LEN - 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(NUM_TAPS*LINE_LEN + 1);

    logic [PTR_W-1:0]                   ptr_q, ptr_d;
    logic [FILL_W-1:0]                  fill_q, fill_d;
    logic [NUM_TAPS-1:0]                valid_q, valid_d;
    logic                               le_q, le_d;
    logic [NUM_TAPS-1:0][DATA_W-1:0]    dout_q, dout_d;
    logic [NUM_TAPS-1:0][DATA_W-1:0]    rd_data;
    logic [NUM_TAPS-1:0][DATA_W-1:0]    wr_data;

    assign wr_data[0] = bus.DataIn;

    // Each tap is its own RAM; tap k is fed with the word tap k-1 is about to overwrite.
    for (genvar k = 0; k < NUM_TAPS; k++) begin : gen_tap
        logic [DATA_W-1:0] mem_q [LINE_LEN];

        assign rd_data[k] = mem_q[ptr_q];

        if (k > 0) begin : gen_cascade
            assign wr_data[k] = rd_data[k-1];
        end

        always_ff @(posedge CLK) begin
            if (RSTn && bus.Enable) begin
                mem_q[ptr_q] <= wr_data[k];
            end
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        fill_d  = fill_q;
        valid_d = valid_q;
        dout_d  = dout_q;
        le_d    = 1'b0;
        if (bus.Enable) begin
            ptr_d  = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
            fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
            le_d   = (ptr_q == PTR_LAST);
            dout_d = rd_data;
            for (int k = 0; k < NUM_TAPS; k++) begin
                valid_d[k] = valid_q[k] | (fill_d >= FILL_W'((k+1)*LINE_LEN + 1));
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            ptr_q   <= '0;
            fill_q  <= '0;
            valid_q <= '0;
            le_q    <= 1'b0;
            dout_q  <= '0;
        end else begin
            ptr_q   <= ptr_d;
            fill_q  <= fill_d;
            valid_q <= valid_d;
            le_q    <= le_d;
            dout_q  <= dout_d;
        end
    end

    assign bus.TapValid = valid_q;
    assign bus.LineEnd  = le_q;

`ifdef TAP_ZERO_MASK_EN
    // Mask rides on the registered flag so the zero and TapValid change on the same cycle.
    for (genvar k = 0; k < NUM_TAPS; k++) begin : gen_mask
        assign bus.DataOut[k*DATA_W +: DATA_W] = valid_q[k] ? dout_q[k] : '0;
    end
`else
    assign bus.DataOut = dout_q;
`endif

endmodule
